// File: rtl/bigblade_clk_gen_tag_seq_pkg.sv
// Shared types and constants for the clock-generator tag sequencer.
// Node indices are relative to the generator's base node ID.
package bigblade_clk_gen_tag_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_CLIENT_RESET,
    ST_CONFIG,
    ST_DONE
  } state_e;

  localparam logic [1:0] SEL_OSC = 2'd0;
  localparam logic [1:0] SEL_DS  = 2'd1;
  localparam logic [1:0] SEL_EXT = 2'd2;
  localparam logic [1:0] SEL_OFF = 2'd3;

  localparam int NODE_ASYNC = 0;
  localparam int NODE_SEL   = 1;
  localparam int NODE_OSC   = 2;
  localparam int NODE_TRIG  = 3;
  localparam int NODE_DS    = 4;

  // packet index space: 5 client resets, then 9 config packets
  localparam int N_CLIENT = 5;
  localparam int N_PKT    = 14;
  localparam int PIDX_W   = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bigblade_tag_packet_ser.sv
// Serializes one bsg_tag packet: start, len, data_not_reset, node, payload, gap.
// Accepts the next packet during the final gap bit so packets chain back to back.
module bigblade_tag_packet_ser #(
  parameter int lg_width_p  = 4,
  parameter int nid_w_p     = 9,
  parameter int payload_w_p = 7,
  parameter int gap_p       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   v,
  output logic                   ready,
  input  logic [lg_width_p-1:0]  len,
  input  logic                   data_not_reset,
  input  logic [nid_w_p-1:0]     nid,
  input  logic [payload_w_p-1:0] payload,
  output logic                   data,
  output logic                   last
);

  localparam int hdr_w   = 2 + lg_width_p + nid_w_p;
  localparam int frame_w = hdr_w + payload_w_p;
  localparam int cnt_w   = $clog2(frame_w + gap_p + 1);

  logic [frame_w-1:0] sr;
  logic [cnt_w-1:0]   cnt;
  logic               busy;

  assign last  = busy && (cnt == cnt_w'(1));
  assign ready = !busy || last;
  assign data  = busy & sr[0];

  // payload bits above len are zero, so shifting in zeros yields the gap
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      sr   <= '0;
    end else if (v && ready) begin
      busy <= 1'b1;
      cnt  <= cnt_w'(hdr_w + gap_p) + cnt_w'(len);
      sr   <= {payload, nid, data_not_reset, len, 1'b1};
    end else if (busy) begin
      busy <= !last;
      cnt  <= cnt - cnt_w'(1);
      sr   <= sr >> 1;
    end
  end

endmodule

// File: rtl/bigblade_clk_gen_tag_seq.sv
// Drives the bsg_tag programming sequence for one clock generator:
// optional preamble and client resets, then nine configuration packets.
module bigblade_clk_gen_tag_seq
  import bigblade_clk_gen_tag_seq_pkg::*;
#(
  parameter int tag_els_p      = 512,
  parameter int tag_lg_width_p = 4,
  parameter int ds_width_p     = 6,
  parameter int osc_width_p    = 5,
  parameter int gap_p          = 4,
  parameter int preamble_p     = 32,
  localparam int nid_w = $clog2(tag_els_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [nid_w-1:0]       node_id_offset_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [osc_width_p-1:0] osc_i,
  input  logic [ds_width_p-1:0]  ds_i,
  input  logic [1:0]             sel_i,
  output logic                   tag_data_o,
  output logic                   done_o
);

  localparam int pw      = max3(osc_width_p, ds_width_p + 1, 2);
  localparam int pre_len = preamble_p + gap_p;
  localparam int pre_w   = $clog2(pre_len + 1);

  state_e state, state_n;

  logic                    first_q, first_n;
  logic [PIDX_W-1:0]       pidx, pidx_n;
  logic [pre_w-1:0]        pre_cnt, pre_n;
  logic [osc_width_p-1:0]  osc_q;
  logic [ds_width_p-1:0]   ds_q;
  logic [1:0]              sel_q;
  logic [nid_w-1:0]        off_q;

  logic                    accept;
  logic                    pre_bit;
  logic                    ser_v;
  logic                    ser_ready;
  logic                    ser_data;
  logic                    ser_last;

  logic [2:0]              node_k;
  logic                    dnr;
  logic [pw-1:0]           pay;
  logic [tag_lg_width_p-1:0] plen;
  logic [nid_w:0]          nid_sum;
  logic [nid_w-1:0]        nid;

  function automatic int node_w(input int k);
    case (k)
      NODE_ASYNC: return 1;
      NODE_SEL:   return 2;
      NODE_OSC:   return osc_width_p;
      NODE_TRIG:  return 1;
      NODE_DS:    return ds_width_p + 1;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [pw-1:0] ones(input int w);
    logic [pw-1:0] m;
    m = '0;
    for (int i = 0; i < pw; i++)
      if (i < w) m[i] = 1'b1;
    return m;
  endfunction

  assign ready_o    = (state == ST_IDLE);
  assign done_o     = (state == ST_DONE);
  assign accept     = ready_o & v_i;
  assign tag_data_o = pre_bit | ser_data;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= ST_IDLE;
      first_q <= 1'b1;
      pidx    <= '0;
      pre_cnt <= '0;
      osc_q   <= '0;
      ds_q    <= '0;
      sel_q   <= '0;
      off_q   <= '0;
    end else begin
      state   <= state_n;
      first_q <= first_n;
      pidx    <= pidx_n;
      pre_cnt <= pre_n;
      if (accept) begin
        osc_q <= osc_i;
        ds_q  <= ds_i;
        sel_q <= sel_i;
        off_q <= node_id_offset_i;
      end
    end
  end

  // pidx counts packets handed to the serializer, not packets finished
  always_comb begin
    state_n = state;
    first_n = first_q;
    pidx_n  = pidx;
    pre_n   = pre_cnt;
    ser_v   = 1'b0;
    pre_bit = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (v_i) begin
          first_n = 1'b0;
          if (first_q) begin
            state_n = ST_PREAMBLE;
            pre_n   = '0;
            pidx_n  = '0;
          end else begin
            state_n = ST_CONFIG;
            pidx_n  = PIDX_W'(N_CLIENT);
          end
        end
      end
      ST_PREAMBLE: begin
        pre_bit = (pre_cnt < pre_w'(preamble_p));
        pre_n   = pre_cnt + pre_w'(1);
        if (pre_cnt == pre_w'(pre_len - 1)) begin
          ser_v   = 1'b1;
          state_n = ST_CLIENT_RESET;
        end
      end
      ST_CLIENT_RESET: begin
        ser_v = (pidx != PIDX_W'(N_PKT));
        if (ser_last && pidx == PIDX_W'(N_CLIENT))
          state_n = ST_CONFIG;
      end
      ST_CONFIG: begin
        ser_v = (pidx != PIDX_W'(N_PKT));
        if (ser_last && pidx == PIDX_W'(N_PKT))
          state_n = ST_DONE;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    if (ser_v && ser_ready)
      pidx_n = pidx + PIDX_W'(1);
  end

  always_comb begin
    node_k = pidx[2:0];
    dnr    = 1'b1;
    pay    = '0;
    unique case (pidx)
      4'd5: begin
        node_k   = 3'(NODE_SEL);
        pay[1:0] = SEL_OFF;
      end
      4'd6: begin
        node_k = 3'(NODE_ASYNC);
        pay[0] = 1'b1;
      end
      4'd7: begin
        node_k = 3'(NODE_OSC);
        pay[osc_width_p-1:0] = osc_q;
      end
      4'd8: begin
        node_k = 3'(NODE_TRIG);
        pay[0] = 1'b1;
      end
      4'd9: begin
        node_k = 3'(NODE_TRIG);
      end
      4'd10: begin
        node_k = 3'(NODE_ASYNC);
      end
      4'd11: begin
        node_k = 3'(NODE_DS);
        pay[ds_width_p:0] = {ds_q, 1'b1};
      end
      4'd12: begin
        node_k = 3'(NODE_DS);
        pay[ds_width_p:0] = {ds_q, 1'b0};
      end
      4'd13: begin
        node_k   = 3'(NODE_SEL);
        pay[1:0] = sel_q;
      end
      default: begin
        dnr = 1'b0;
        pay = ones(node_w(int'(node_k)));
      end
    endcase
    plen = tag_lg_width_p'(node_w(int'(node_k)));
  end

  assign nid_sum = {1'b0, off_q} + (nid_w + 1)'(node_k);
  assign nid = (nid_sum >= (nid_w + 1)'(tag_els_p))
             ? nid_w'(nid_sum - (nid_w + 1)'(tag_els_p))
             : nid_sum[nid_w-1:0];

  bigblade_tag_packet_ser #(
    .lg_width_p  (tag_lg_width_p),
    .nid_w_p     (nid_w),
    .payload_w_p (pw),
    .gap_p       (gap_p)
  ) u_ser (
    .clk            (clk_i),
    .reset          (reset_i),
    .v              (ser_v),
    .ready          (ser_ready),
    .len            (plen),
    .data_not_reset (dnr),
    .nid            (nid),
    .payload        (pay),
    .data           (ser_data),
    .last           (ser_last)
  );

endmodule

// File: tb/tb_bigblade_clk_gen_tag_seq.sv
// Scoreboard bench: a bsg_tag client model decodes the serial stream
// and compares every preamble/packet against queued expectations.
module tb_bigblade_clk_gen_tag_seq;

  localparam int PRE = 32;
  localparam int GAP = 4;
  localparam int HDR = 14;

  logic       clk;
  logic       reset_i;
  logic [8:0] node_id_offset_i;
  logic       v_i;
  logic       ready_o;
  logic [4:0] osc_i;
  logic [5:0] ds_i;
  logic [1:0] sel_i;
  logic       tag_data_o;
  logic       done_o;

  bigblade_clk_gen_tag_seq dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .node_id_offset_i (node_id_offset_i),
    .v_i              (v_i),
    .ready_o          (ready_o),
    .osc_i            (osc_i),
    .ds_i             (ds_i),
    .sel_i            (sel_i),
    .tag_data_o       (tag_data_o),
    .done_o           (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          pre;
    logic [8:0]  nid;
    logic [31:0] bits;
  } exp_t;

  exp_t sb[$];
  logic [7:0] cl [512];

  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic int wid(input int k);
    case (k)
      0: return 1;
      1: return 2;
      2: return 5;
      3: return 1;
      default: return 7;
    endcase
  endfunction

  function automatic logic [8:0] nid_of(input logic [8:0] off, input int k);
    return 9'((int'(off) + k) % 512);
  endfunction

  function automatic exp_t mk(input int k, input bit dnr,
                              input logic [7:0] pay, input logic [8:0] off);
    exp_t e;
    e.pre  = 1'b0;
    e.nid  = nid_of(off, k);
    e.bits = (32'(pay) << HDR) | (32'(e.nid) << 5) |
             (32'(dnr) << 4) | 32'(wid(k));
    return e;
  endfunction

  task automatic push_seq(input logic [4:0] o, input logic [5:0] d,
                          input logic [1:0] s, input logic [8:0] off,
                          input bit first);
    exp_t e;
    int cn [9];
    logic [7:0] cp [9];
    cn = '{1, 0, 2, 3, 3, 0, 4, 4, 1};
    cp = '{8'd3, 8'd1, 8'(o), 8'd1, 8'd0, 8'd0,
           {1'b0, d, 1'b1}, {1'b0, d, 1'b0}, 8'(s)};
    if (first) begin
      e.pre  = 1'b1;
      e.nid  = '0;
      e.bits = '0;
      sb.push_back(e);
      for (int k = 0; k < 5; k++)
        sb.push_back(mk(k, 1'b0, 8'((1 << wid(k)) - 1), off));
    end
    for (int i = 0; i < 9; i++)
      sb.push_back(mk(cn[i], 1'b1, cp[i], off));
  endtask

  // client model / decoder
  localparam int D_IDLE = 0, D_PRE = 1, D_PKT = 2, D_GAP = 3;
  int          dstate = D_IDLE;
  int          ones_n, bitpos, gcnt;
  exp_t        cur;
  logic [31:0] rx;

  initial begin
    cur.pre = 1'b0;
    cur.nid = '0;
    cur.bits = '0;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        dstate = D_IDLE;
      end else begin
        case (dstate)
          D_IDLE: if (tag_data_o) begin
            chk("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
              cur    = sb.pop_front();
              rx     = '0;
              bitpos = 0;
              ones_n = 1;
              dstate = cur.pre ? D_PRE : D_PKT;
            end
          end
          D_PRE: begin
            if (tag_data_o) ones_n++;
            else begin
              chk("preamble_ones", ones_n, PRE);
              gcnt   = 1;
              dstate = (GAP == 1) ? D_IDLE : D_GAP;
            end
          end
          D_PKT: begin
            rx[bitpos] = tag_data_o;
            bitpos++;
            if (bitpos >= HDR && bitpos == HDR + int'(rx[3:0])) begin
              chk("pkt", rx, cur.bits);
              if (rx[4]) cl[rx[13:5]] = 8'(rx >> HDR);
              gcnt   = 0;
              dstate = D_GAP;
            end
          end
          default: begin
            chk("gap_zero", tag_data_o, 0);
            gcnt++;
            if (gcnt == GAP) dstate = D_IDLE;
          end
        endcase
      end
    end
  end

  initial forever begin
    @(posedge clk);
    if (done_o) n_done++;
  end

  task automatic do_req(input logic [4:0] o, input logic [5:0] d,
                        input logic [1:0] s, input logic [8:0] off,
                        input bit first);
    int n = 0;
    osc_i = o;
    ds_i = d;
    sel_i = s;
    node_id_offset_i = off;
    v_i = 1'b1;
    while (!ready_o && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready", ready_o, 1);
    push_seq(o, d, s, off, first);
    @(posedge clk); #1;
    v_i = 1'b0;
    osc_i = ~o;
    ds_i = ~d;
    sel_i = ~s;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", done_o, 1);
    chk("ready_in_done", ready_o, 0);
    chk("sb_drained", sb.size(), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done_o, 0);
    chk("ready_after_done", ready_o, 1);
    chk("idle_tag_zero", tag_data_o, 0);
  endtask

  task automatic check_client(input logic [4:0] o, input logic [5:0] d,
                              input logic [1:0] s, input logic [8:0] off);
    chk("cl_async", cl[nid_of(off, 0)], 8'd0);
    chk("cl_sel", cl[nid_of(off, 1)], 8'(s));
    chk("cl_osc", cl[nid_of(off, 2)], 8'(o));
    chk("cl_trig", cl[nid_of(off, 3)], 8'd0);
    chk("cl_ds", cl[nid_of(off, 4)], {1'b0, d, 1'b0});
  endtask

  initial begin
    int n;
    int acc;
    int d0;
    logic [4:0] lo;
    logic [5:0] ld;
    logic [1:0] ls;
    reset_i = 1'b1;
    v_i = 1'b0;
    osc_i = '0;
    ds_i = '0;
    sel_i = '0;
    node_id_offset_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_tag", tag_data_o, 0);
    chk("rst_done", done_o, 0);
    reset_i = 1'b0;

    do_req(5'h13, 6'd3, 2'd1, 9'd0, 1'b1);
    wait_done();
    check_client(5'h13, 6'd3, 2'd1, 9'd0);

    do_req(5'h01, 6'd0, 2'd0, 9'd0, 1'b0);
    wait_done();
    check_client(5'h01, 6'd0, 2'd0, 9'd0);

    // abort in the middle of the osc packet
    do_req(5'h0a, 6'd9, 2'd2, 9'd0, 1'b0);
    n = 0;
    while (!(dstate == D_PKT && cur.nid == 9'd2 && bitpos > 8) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reached", n < 3000, 1);
    reset_i = 1'b1;
    v_i = 1'b1;
    @(posedge clk); #1;
    chk("abort_tag", tag_data_o, 0);
    chk("abort_ready", ready_o, 1);
    chk("abort_done", done_o, 0);
    reset_i = 1'b0;
    v_i = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    chk("rst_v_ignored", ready_o, 1);
    chk("post_abort_tag", tag_data_o, 0);

    // fresh preamble and wrapping client-reset node IDs
    do_req(5'h1f, 6'h2a, 2'd3, 9'd510, 1'b1);
    wait_done();
    check_client(5'h1f, 6'h2a, 2'd3, 9'd510);

    // v_i held high with fields changing every cycle
    d0 = n_done;
    acc = 0;
    n = 0;
    lo = '0;
    ld = '0;
    ls = '0;
    node_id_offset_i = 9'd510;
    v_i = 1'b1;
    while (acc < 3 && n < 5000) begin
      osc_i = 5'($urandom);
      ds_i = 6'($urandom);
      sel_i = 2'($urandom);
      if (ready_o) begin
        push_seq(osc_i, ds_i, sel_i, 9'd510, 1'b0);
        lo = osc_i;
        ld = ds_i;
        ls = sel_i;
        acc++;
      end
      @(posedge clk); #1;
      n++;
    end
    v_i = 1'b0;
    chk("cont_accepts", acc, 3);
    wait_done();
    chk("cont_dones", n_done - d0, 3);
    check_client(lo, ld, ls, 9'd510);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bigblade_clk_gen_tag_seq.md
BIGBLADE_CLK_GEN_TAG_SEQ -- requirements
Module: bigblade_clk_gen_tag_seq

Interface
REQ-001 SHALL have parameter tag_els_p, default 512: node-ID space of the tag network; node-ID field width nid_w = clog2(tag_els_p).
REQ-002 SHALL have parameter tag_lg_width_p, default 4: width of the packet length field.
REQ-003 SHALL have parameter ds_width_p, default 6: downsampler value width; ds payload is ds_width_p+1 bits, {value, ds_reset}.
REQ-004 SHALL have parameter osc_width_p, default 5: oscillator setting payload width.
REQ-005 SHALL have parameter gap_p, default 4: idle zero bits after every packet.
REQ-006 SHALL have parameter preamble_p, default 32: count of ones in the tag-master reset preamble.
REQ-007 clk_i  in  1  tag clock; one serial bit per cycle; single clock domain; reset is synchronous, active-high.
REQ-008 reset_i  in  1  synchronous active-high reset.
REQ-009 node_id_offset_i  in  nid_w  base node ID; target clock generator uses offset+0 (async reset), +1 (select), +2 (osc), +3 (osc trigger), +4 (ds).
REQ-010 v_i  in  1  configuration request valid.
REQ-011 ready_o  out  1  high only in IDLE; a request is accepted when v_i & ready_o.
REQ-012 osc_i  in  osc_width_p  oscillator setting.
REQ-013 ds_i  in  ds_width_p  downsample value.
REQ-014 sel_i  in  2  final clock select: 0 osc, 1 downsampled, 2 external, 3 off.
REQ-015 tag_data_o  out  1  serial tag stream to the clock generator tag input.
REQ-016 done_o  out  1  one-cycle pulse when the last packet's final gap bit has been sent.

Function
REQ-017 Request fields SHALL be registered on acceptance; later input changes SHALL not affect an in-flight sequence.
REQ-018 Packet bit order SHALL be: start bit 1; len (tag_lg_width_p bits, LSB first) = payload width; data_not_reset (1); node ID = offset+k (nid_w bits, LSB first); payload (len bits, LSB first); then gap_p zeros.
REQ-019 Node-ID sum SHALL wrap modulo tag_els_p.
REQ-020 The first accepted request after reset SHALL first send the PREAMBLE (preamble_p ones, then gap_p zeros), then CLIENT_RESET packets (data_not_reset=0, payload all ones) to nodes +0..+4 in order; later requests SHALL skip both.
REQ-021 Every request SHALL then send data packets in this fixed order: sel=3; async_reset=1; osc=osc_i; trigger=1; trigger=0; async_reset=0; ds={ds_i,1}; ds={ds_i,0}; sel=sel_i.
REQ-022 FSM states SHALL be IDLE, PREAMBLE, CLIENT_RESET, CONFIG, DONE; IDLE->PREAMBLE (first request) or IDLE->CONFIG; PREAMBLE->CLIENT_RESET after gap; CLIENT_RESET->CONFIG after fifth packet; CONFIG->DONE after ninth packet; DONE->IDLE in one cycle with done_o=1.
REQ-023 tag_data_o SHALL be 0 whenever no packet or preamble bit is being driven, including IDLE and DONE.
REQ-024 Bit counters SHALL be sized for the longest packet (1+tag_lg_width_p+1+nid_w+max payload+gap_p) without overflow.
REQ-025 A new request SHALL not be accepted earlier than the cycle after done_o (ready_o low in DONE).
REQ-026 v_i asserted together with reset_i SHALL be ignored.

Reset
REQ-027 reset_i SHALL force IDLE, ready_o=1, tag_data_o=0, done_o=0, and set the first-request flag, aborting any sequence mid-packet.
REQ-028 An aborted sequence SHALL not be resumed; the next request re-sends the preamble and client resets.

Structure
REQ-029 A package bigblade_clk_gen_tag_seq_pkg SHALL hold the FSM state enum, the select encodings, and node-index constants 0..4.
REQ-030 A sub-module bigblade_tag_packet_ser SHALL serialize one packet (header+payload+gap) with v/ready load handshake and a last-bit pulse; the top-level FSM only chooses node, data_not_reset and payload.

Verification
REQ-031 Reset, then request osc=5'h13, ds=6'd3, sel=1, offset=0 -> 32 ones, 4 zeros, 5 client-reset packets, 9 config packets with node IDs 1,0,2,3,3,0,4,4,1; done_o pulses once.
REQ-032 Second request osc=5'h01, ds=6'd0, sel=0 -> no preamble, first bit after the IDLE zeros is the sel=3 packet start; the bench decodes all 9 payloads correctly.
REQ-033 Offset=510, tag_els_p=512 -> node IDs wrap to 510,511,0,1,2.
REQ-034 reset_i pulsed mid osc packet -> tag_data_o=0 the next cycle; the next request restarts with the preamble.
REQ-035 v_i held high continuously with changing fields -> exactly one sequence per done_o, each using the fields sampled at acceptance.
REQ-036 A behavioural bsg_tag master/client model -> after done_o, client outputs equal sel_i, async_reset=0, osc_i, {ds_i,0}.
